// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out converter.
package piso_pkg;
  typedef enum logic {IDLE, BUSY} piso_state_e;
endpackage

// File: rtl/piso.sv
// Parallel-in/serial-out converter: one DEPTH-word vector in, one word per
// output handshake out, word 0 first, with no bubble between vectors.
module piso
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 5
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [DEPTH*DATA_WIDTH-1:0] data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  piso_state_e                          state, state_d;
  logic [CW-1:0]                        cnt, cnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     shreg, shreg_d;
  logic                                 load, pop;

  assign data_out       = shreg[0];
  assign data_out_valid = (state == BUSY);
  // Ready may follow data_out_ready combinationally so a new vector can be
  // taken on the edge that consumes the last word of the current one.
  assign data_in_ready  = (state == IDLE) | ((cnt == CW'(1)) & data_out_ready);

  assign load = data_in_valid & data_in_ready;
  assign pop  = data_out_valid & data_out_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    if (load) begin
      // A load on the last-word edge overrides the shift; that word still leaves.
      shreg_d = data_in;
      cnt_d   = CW'(DEPTH);
      state_d = BUSY;
    end else if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++)
        shreg_d[k] = shreg[k+1];
      shreg_d[DEPTH-1] = '0;
      cnt_d   = cnt - CW'(1);
      state_d = (cnt == CW'(1)) ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
    end
  end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: table-driven DEPTH=4 streaming plus hand-written
// reset and DEPTH=1 register-slice sequences.
module tb_piso;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic [31:0] d4_in = '0;
  logic        d4_in_valid = 1'b0, d4_in_ready;
  logic [7:0]  d4_out;
  logic        d4_out_valid, d4_out_ready = 1'b1;

  // DEPTH=1 instance
  logic [7:0]  d1_in = '0;
  logic        d1_in_valid = 1'b0, d1_in_ready;
  logic [7:0]  d1_out;
  logic        d1_out_valid, d1_out_ready = 1'b1;

  piso #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
    .clk_i(clk), .arst_i(arst),
    .data_in(d4_in), .data_in_valid(d4_in_valid), .data_in_ready(d4_in_ready),
    .data_out(d4_out), .data_out_valid(d4_out_valid), .data_out_ready(d4_out_ready)
  );

  piso #(.DATA_WIDTH(8), .DEPTH(1)) u1 (
    .clk_i(clk), .arst_i(arst),
    .data_in(d1_in), .data_in_valid(d1_in_valid), .data_in_ready(d1_in_ready),
    .data_out(d1_out), .data_out_valid(d1_out_valid), .data_out_ready(d1_out_ready)
  );

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic        ordy;
    logic        ovld;
    logic [7:0]  dout;
    logic        irdy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic vld, input logic [31:0] din, input logic ordy,
                     input logic ovld, input logic [7:0] dout, input logic irdy);
    vec_t v;
    v.vld = vld; v.din = din; v.ordy = ordy;
    v.ovld = ovld; v.dout = dout; v.irdy = irdy;
    tbl.push_back(v);
  endtask

  task automatic chk4(input string tag, input logic ovld, input logic [7:0] dout, input logic irdy);
    chk({tag, ".valid"}, {31'd0, d4_out_valid}, {31'd0, ovld});
    chk({tag, ".data"},  {24'd0, d4_out},       {24'd0, dout});
    chk({tag, ".ready"}, {31'd0, d4_in_ready},  {31'd0, irdy});
  endtask

  logic [7:0] w1[5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

  initial begin
    // Rows: inputs for the cycle, expected outputs before the next edge.
    // basic
    add(1, 32'hDDCCBBAA, 1, 0, 8'h00, 1);
    add(0, 32'h0,        1, 1, 8'hAA, 0);
    add(0, 32'h0,        1, 1, 8'hBB, 0);
    add(0, 32'h0,        1, 1, 8'hCC, 0);
    add(0, 32'h0,        1, 1, 8'hDD, 1);
    add(0, 32'h0,        1, 0, 8'h00, 1);
    // back-to-back, second vector held valid throughout
    add(1, 32'hDDCCBBAA, 1, 0, 8'h00, 1);
    add(1, 32'h44332211, 1, 1, 8'hAA, 0);
    add(1, 32'h44332211, 1, 1, 8'hBB, 0);
    add(1, 32'h44332211, 1, 1, 8'hCC, 0);
    add(1, 32'h44332211, 1, 1, 8'hDD, 1);
    add(0, 32'h0,        1, 1, 8'h11, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0);
    add(0, 32'h0,        1, 1, 8'h33, 0);
    add(0, 32'h0,        1, 1, 8'h44, 1);
    add(0, 32'h0,        1, 0, 8'h00, 1);
    // backpressure, with a stray vector offered while stalled
    add(1, 32'hDDCCBBAA, 1, 0, 8'h00, 1);
    add(0, 32'h0,        1, 1, 8'hAA, 0);
    add(1, 32'h55555555, 0, 1, 8'hBB, 0);
    add(1, 32'h55555555, 0, 1, 8'hBB, 0);
    add(1, 32'h55555555, 0, 1, 8'hBB, 0);
    add(0, 32'h0,        1, 1, 8'hBB, 0);
    add(0, 32'h0,        1, 1, 8'hCC, 0);
    add(1, 32'h55555555, 0, 1, 8'hDD, 0);
    add(0, 32'h0,        1, 1, 8'hDD, 1);
    add(0, 32'h0,        1, 0, 8'h00, 1);

    // Reset is asserted from time 0: outputs must already be cleared.
    #3;
    chk4("reset", 0, 8'h00, 1);
    chk("reset.d1_valid", {31'd0, d1_out_valid}, 32'd0);
    @(posedge clk); #2 arst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      d4_in = tbl[i].din; d4_in_valid = tbl[i].vld; d4_out_ready = tbl[i].ordy;
      #3;
      chk4($sformatf("row%0d", i), tbl[i].ovld, tbl[i].dout, tbl[i].irdy);
      @(posedge clk); #1;
    end

    // Mid-vector reset while CC is shown
    d4_in = 32'hDDCCBBAA; d4_in_valid = 1; d4_out_ready = 1;
    @(posedge clk); #1 d4_in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk4("mrst.pre", 1, 8'hCC, 0);
    #1 arst = 1'b1;
    #1 chk4("mrst.async", 0, 8'h00, 1);
    @(posedge clk); #1;
    chk4("mrst.hold", 0, 8'h00, 1);
    #1 arst = 1'b0;
    d4_in = 32'h04030201; d4_in_valid = 1;
    #2 chk4("mrst.idle", 0, 8'h00, 1);
    @(posedge clk); #1 d4_in_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      #2 chk4($sformatf("mrst.w%0d", k), 1, 8'(k), (k == 4));
      @(posedge clk); #1;
    end
    #2 chk4("mrst.done", 0, 8'h00, 1);

    // DEPTH=1 slice with random consumer backpressure
    begin
      int sent = 0, rcvd = 0, cyc = 0;
      logic hin, hout;
      @(posedge clk); #1;
      while (rcvd < 5 && cyc < 200) begin
        d1_out_ready = 1'($urandom_range(0, 1));
        d1_in_valid  = (sent < 5);
        d1_in        = (sent < 5) ? w1[sent] : 8'h00;
        #3;
        chk("d1.ready", {31'd0, d1_in_ready}, {31'd0, (~d1_out_valid | d1_out_ready)});
        hin  = d1_in_valid & d1_in_ready;
        hout = d1_out_valid & d1_out_ready;
        if (hout) begin
          chk($sformatf("d1.word%0d", rcvd), {24'd0, d1_out}, {24'd0, w1[rcvd]});
          rcvd++;
        end
        if (hin) sent++;
        cyc++;
        @(posedge clk); #1;
      end
      d1_in_valid = 0;
      chk("d1.count", rcvd, 5);
      #2 chk("d1.idle", {31'd0, d1_out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
